// File: rtl/pulse_width_receiver_n.sv
// -----------------------------------------------------------------------------
// pulse_width_receiver_n
//
// Single-wire pulse-width message receiver. Each bit on rx_in is one high
// pulse followed by a low gap. A high pulse longer than ONE_THRESH cycles is a
// 1, otherwise a 0. MSG_BITS bits are assembled MSB-first and handed over with
// a valid/ack handshake.
//
// The receiver also:
//   - synchronises rx_in through two flops,
//   - aborts a message on a low gap timeout,
//   - rejects runt pulses and stuck-high lines,
//   - flags a complete message dropped while msg_valid was already high.
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset, clears all state
//   rx_in       in   raw serial line (asynchronous to clock, idle low)
//   msg_ack     in   consumer accept, only honoured while msg_valid=1
//   msg_valid   out  msg_data holds an unacknowledged message
//   msg_data    out  last accepted message, first received bit at MSB
//   frame_err   out  one-cycle pulse on any framing abort
//   overrun     out  sticky, a complete message was dropped
//   busy        out  a message is partially received
//   parity_err  out  only with PARITY_CHECK_EN: one-cycle pulse on bad parity
//
// Optional feature macro: PARITY_CHECK_EN
//   When defined, every message carries one extra trailing pulse. That pulse
//   is an even-parity bit over the payload. On a mismatch the message is
//   discarded, and parity_err and frame_err pulse together. The parity bit is
//   never stored in msg_data.
// -----------------------------------------------------------------------------
module pulse_width_receiver_n #(
  parameter int MSG_BITS    = 24,
  parameter int CNT_WIDTH   = 8,
  parameter int ONE_THRESH  = 26,
  parameter int MIN_HIGH    = 4,
  parameter int MAX_HIGH    = 200,
  parameter int GAP_TIMEOUT = 200
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rx_in,
  input  logic                msg_ack,
  output logic                msg_valid,
  output logic [MSG_BITS-1:0] msg_data,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
`ifdef PARITY_CHECK_EN
  ,
  output logic                parity_err
`endif
);

`ifdef PARITY_CHECK_EN
  localparam int TOTAL_PULSES = MSG_BITS + 1;
`else
  localparam int TOTAL_PULSES = MSG_BITS;
`endif
  // The bit counter must be able to hold the pulse count that completes a
  // message. That count is MSG_BITS, or MSG_BITS+1 when a parity pulse follows.
  localparam int BCNT_W = $clog2(TOTAL_PULSES + 1);
  // Run lengths are one wider than the counter so that count+1 cannot wrap.
  localparam int RUN_W  = CNT_WIDTH + 1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};
  localparam logic [RUN_W-1:0]     ONE_THRESH_R = RUN_W'(ONE_THRESH);
  localparam logic [RUN_W-1:0]     MIN_HIGH_R   = RUN_W'(MIN_HIGH);
  localparam logic [RUN_W-1:0]     MAX_HIGH_R   = RUN_W'(MAX_HIGH);
  localparam logic [RUN_W-1:0]     GAP_R        = RUN_W'(GAP_TIMEOUT);
  localparam logic [BCNT_W-1:0]    PAYLOAD_CNT  = BCNT_W'(MSG_BITS);
  localparam logic [BCNT_W-1:0]    LAST_CNT     = BCNT_W'(TOTAL_PULSES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RCV_HIGH = 2'd1,
    ST_RCV_LOW  = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

`ifdef PARITY_CHECK_EN
  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [MSG_BITS-1:0] data);
    return ^data;
  endfunction
`endif

  // Registered state.
  logic                sync1_q,     sync1_d;
  logic                sync2_q,     sync2_d;
  logic                rx_prev_q,   rx_prev_d;
  logic [CNT_WIDTH-1:0] cnt_q,      cnt_d;
  state_t              state_q,     state_d;
  logic [BCNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [MSG_BITS-1:0] shift_q,     shift_d;
  logic                msg_valid_q, msg_valid_d;
  logic [MSG_BITS-1:0] msg_data_q,  msg_data_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q,   overrun_d;
  logic                busy_q,      busy_d;
  logic                parity_err_q, parity_err_d;

  // Combinational helpers.
  logic             rx_s;
  logic             edge_s;
  logic [RUN_W-1:0] run_len_s;
  logic             bit_s;
  logic             complete_s;
  logic             parity_ok_s;
  logic             ack_take_s;

  assign rx_s   = sync2_q;
  assign edge_s = rx_s ^ rx_prev_q;
  // The counter is cleared on the cycle a transition is seen. One cycle later
  // it reads 0, even though the level has already lasted one cycle. Adding 1
  // therefore gives the number of cycles the previous level lasted. At a
  // falling edge this equals the high pulse width.
  assign run_len_s  = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign ack_take_s = msg_ack & msg_valid_q;

  // Next-state logic for the synchroniser, counter, FSM and outputs.
  always_comb begin
    sync1_d      = rx_in;
    sync2_d      = sync1_q;
    rx_prev_d    = rx_s;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    msg_valid_d  = msg_valid_q;
    msg_data_d   = msg_data_q;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;
    parity_err_d = 1'b0;
    bit_s        = 1'b0;
    complete_s   = 1'b0;
    parity_ok_s  = 1'b1;

    if (edge_s) begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    case (state_q)
      ST_IDLE: begin
        // The cycle counter is not touched here; the transition that raised
        // rx_s already cleared it. The pulse width is therefore correct even
        // if rx_s rose on the cycle this state was entered.
        if (rx_s) begin
          state_d   = ST_RCV_HIGH;
          bit_cnt_d = {BCNT_W{1'b0}};
          shift_d   = {MSG_BITS{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RCV_HIGH: begin
        if (run_len_s >= MAX_HIGH_R) begin
          frame_err_d = 1'b1;
          state_d     = ST_WAIT_LOW;
        end else if (!rx_s) begin
          if (run_len_s < MIN_HIGH_R) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            bit_s     = (run_len_s > ONE_THRESH_R);
            bit_cnt_d = bit_cnt_q + {{(BCNT_W-1){1'b0}}, 1'b1};
            // Only payload bits enter the shift register; a trailing parity
            // pulse is kept out.
            if (bit_cnt_q < PAYLOAD_CNT) begin
              shift_d = {shift_q[MSG_BITS-2:0], bit_s};
            end else begin
              shift_d = shift_q;
            end
            if (bit_cnt_d == LAST_CNT) begin
              complete_s = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_RCV_LOW;
            end
          end
        end else begin
          state_d = ST_RCV_HIGH;
        end
      end
      ST_RCV_LOW: begin
        if (run_len_s >= GAP_R) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (rx_s) begin
          state_d = ST_RCV_HIGH;
        end else begin
          state_d = ST_RCV_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef PARITY_CHECK_EN
    // On the completing edge, bit_s is the parity pulse and shift_q holds the
    // whole payload.
    parity_ok_s = (even_parity(shift_q) == bit_s);
`endif

    // Handshake. On a completing cycle an accepted ack frees the holding
    // register first, so the new message loads with no valid gap.
    if (complete_s) begin
      if (!parity_ok_s) begin
        frame_err_d  = 1'b1;
        parity_err_d = 1'b1;
      end else if (!msg_valid_q || ack_take_s) begin
        msg_data_d  = shift_d;
        msg_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (ack_take_s) begin
      msg_valid_d = 1'b0;
    end else begin
      msg_valid_d = msg_valid_q;
    end

    busy_d = (state_d == ST_RCV_HIGH) || (state_d == ST_RCV_LOW);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      rx_prev_q    <= 1'b0;
      cnt_q        <= {CNT_WIDTH{1'b0}};
      state_q      <= ST_IDLE;
      bit_cnt_q    <= {BCNT_W{1'b0}};
      shift_q      <= {MSG_BITS{1'b0}};
      msg_valid_q  <= 1'b0;
      msg_data_q   <= {MSG_BITS{1'b0}};
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      rx_prev_q    <= rx_prev_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      msg_valid_q  <= msg_valid_d;
      msg_data_q   <= msg_data_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign msg_valid = msg_valid_q;
  assign msg_data  = msg_data_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  // Without the parity port the register never sets and has no reader.
  logic unused_parity_s;
  assign unused_parity_s = parity_err_q;
`endif

endmodule

// File: tb/tb_pulse_width_receiver_n.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for pulse_width_receiver_n.
//
// dut  : default parameters (24-bit messages)
// dut2 : MSG_BITS=2, used for the decode threshold boundary
// -----------------------------------------------------------------------------
module tb_pulse_width_receiver_n;

`ifdef PARITY_CHECK_EN
  localparam bit PAR_MODE = 1'b1;
`else
  localparam bit PAR_MODE = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        rx_in;
  logic        msg_ack;
  logic        msg_valid;
  logic [23:0] msg_data;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  logic        rx2;
  logic        ack2;
  logic        valid2;
  logic [1:0]  data2;
  logic        frame2;
  logic        overrun2;
  logic        busy2;

`ifdef PARITY_CHECK_EN
  logic        parity_err;
  logic        parity2;
  logic        par_n3;
`endif

  int checks_total;
  int checks_passed;

  logic        valid_n2;
  logic        valid_n3;
  logic [23:0] data_n3;
  logic        frame_n3;
  logic        overrun_n3;

  pulse_width_receiver_n dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_in     (rx_in),
    .msg_ack   (msg_ack),
    .msg_valid (msg_valid),
    .msg_data  (msg_data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef PARITY_CHECK_EN
    ,
    .parity_err(parity_err)
`endif
  );

  pulse_width_receiver_n #(.MSG_BITS(2)) dut2 (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_in     (rx2),
    .msg_ack   (ack2),
    .msg_valid (valid2),
    .msg_data  (data2),
    .frame_err (frame2),
    .overrun   (overrun2),
    .busy      (busy2)
`ifdef PARITY_CHECK_EN
    ,
    .parity_err(parity2)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // High pulse of w clocks on rx_in; called and returns on a falling edge.
  task automatic pulse(input int w);
    rx_in = 1'b1;
    repeat (w) @(negedge clock);
    rx_in = 1'b0;
  endtask

  task automatic pulse2(input int w);
    rx2 = 1'b1;
    repeat (w) @(negedge clock);
    rx2 = 1'b0;
  endtask

  // Samples around the completing pulse. The fall is set at N0; N2 lies
  // before and N3 after the edge where msg_valid is due to rise.
  task automatic finish_tail(input logic ack_at_done);
    @(negedge clock);
    @(negedge clock);
    valid_n2 = msg_valid;
    if (ack_at_done) msg_ack = 1'b1;
    @(negedge clock);
    msg_ack    = 1'b0;
    valid_n3   = msg_valid;
    data_n3    = msg_data;
    frame_n3   = frame_err;
    overrun_n3 = overrun;
`ifdef PARITY_CHECK_EN
    par_n3 = parity_err;
`endif
    repeat (17) @(negedge clock);
  endtask

  // Sends the top nbits of val MSB-first: 1 is a 40-clock pulse, 0 is a
  // 10-clock pulse, and each pulse is followed by a 20-clock gap.
  task automatic send_msg(input logic [23:0] val, input int nbits,
                          input logic bad_par, input logic ack_at_done);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = val[23-i];
      pulse(b ? 40 : 10);
      if (!PAR_MODE && (nbits == 24) && (i == nbits - 1)) finish_tail(ack_at_done);
      else repeat (20) @(negedge clock);
    end
    if (PAR_MODE && (nbits == 24)) begin
      b = (^val) ^ bad_par;
      pulse(b ? 40 : 10);
      finish_tail(ack_at_done);
    end
  endtask

  task automatic ack_once;
    msg_ack = 1'b1;
    @(negedge clock);
    msg_ack = 1'b0;
  endtask

  task automatic test_reset;
    checks_total++; if (msg_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", msg_valid); else checks_passed++;
    checks_total++; if (msg_data !== 24'h000000) $display("FAIL reset_data: got %06h want 000000", msg_data); else checks_passed++;
    checks_total++; if (frame_err !== 1'b0) $display("FAIL reset_frame: got %0b want 0", frame_err); else checks_passed++;
    checks_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b want 0", overrun); else checks_passed++;
    checks_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else checks_passed++;
  endtask

  task automatic test_main;
    send_msg(24'hA5C3F0, 24, 1'b0, 1'b0);
    checks_total++; if (valid_n2 !== 1'b0) $display("FAIL main_early_valid: got %0b want 0", valid_n2); else checks_passed++;
    checks_total++; if (valid_n3 !== 1'b1) $display("FAIL main_latency_valid: got %0b want 1", valid_n3); else checks_passed++;
    checks_total++; if (data_n3 !== 24'hA5C3F0) $display("FAIL main_data: got %06h want a5c3f0", data_n3); else checks_passed++;
    checks_total++; if (frame_n3 !== 1'b0) $display("FAIL main_frame: got %0b want 0", frame_n3); else checks_passed++;
    repeat (100) @(negedge clock);
    checks_total++; if (msg_valid !== 1'b1) $display("FAIL main_hold_valid: got %0b want 1", msg_valid); else checks_passed++;
    checks_total++; if (msg_data !== 24'hA5C3F0) $display("FAIL main_hold_data: got %06h want a5c3f0", msg_data); else checks_passed++;
    ack_once();
    checks_total++; if (msg_valid !== 1'b0) $display("FAIL main_ack_clear: got %0b want 0", msg_valid); else checks_passed++;
  endtask

  task automatic send_pair(input int w1, input int w0);
    logic p;
    pulse2(w1);
    repeat (20) @(negedge clock);
    pulse2(w0);
    if (PAR_MODE) begin
      p = (w1 > 26) ^ (w0 > 26);
      repeat (20) @(negedge clock);
      pulse2(p ? 40 : 10);
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic test_threshold;
    send_pair(26, 27);
    checks_total++; if (valid2 !== 1'b1) $display("FAIL thresh_a_valid: got %0b want 1", valid2); else checks_passed++;
    checks_total++; if (data2 !== 2'b01) $display("FAIL thresh_26_27: got %02b want 01", data2); else checks_passed++;
    ack2 = 1'b1; @(negedge clock); ack2 = 1'b0;
    send_pair(27, 26);
    checks_total++; if (valid2 !== 1'b1) $display("FAIL thresh_b_valid: got %0b want 1", valid2); else checks_passed++;
    checks_total++; if (data2 !== 2'b10) $display("FAIL thresh_27_26: got %02b want 10", data2); else checks_passed++;
    ack2 = 1'b1; @(negedge clock); ack2 = 1'b0;
  endtask

  task automatic test_timeout;
    int fe;
    fe = 0;
    send_msg(24'hB6D000, 10, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (frame_err === 1'b1) fe++;
    end
    checks_total++; if (fe != 1) $display("FAIL timeout_frame_pulses: got %0d want 1", fe); else checks_passed++;
    checks_total++; if (busy !== 1'b0) $display("FAIL timeout_busy: got %0b want 0", busy); else checks_passed++;
    checks_total++; if (msg_valid !== 1'b0) $display("FAIL timeout_valid: got %0b want 0", msg_valid); else checks_passed++;
    send_msg(24'h123456, 24, 1'b0, 1'b0);
    checks_total++; if (valid_n3 !== 1'b1) $display("FAIL after_timeout_valid: got %0b want 1", valid_n3); else checks_passed++;
    checks_total++; if (data_n3 !== 24'h123456) $display("FAIL after_timeout_data: got %06h want 123456", data_n3); else checks_passed++;
    ack_once();
  endtask

  task automatic test_runt_stuck;
    int fe;
    int fe_after;
    fe = 0;
    pulse(2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (frame_err === 1'b1) fe++;
    end
    checks_total++; if (fe != 1) $display("FAIL runt_frame_pulses: got %0d want 1", fe); else checks_passed++;
    checks_total++; if (busy !== 1'b0) $display("FAIL runt_busy: got %0b want 0", busy); else checks_passed++;
    fe = 0;
    fe_after = 0;
    rx_in = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      if (frame_err === 1'b1) fe++;
    end
    rx_in = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (frame_err === 1'b1) fe_after++;
    end
    checks_total++; if (fe != 1) $display("FAIL stuck_frame_pulses: got %0d want 1", fe); else checks_passed++;
    checks_total++; if (fe_after != 0) $display("FAIL stuck_after_fall: got %0d want 0", fe_after); else checks_passed++;
    checks_total++; if (busy !== 1'b0) $display("FAIL stuck_busy: got %0b want 0", busy); else checks_passed++;
  endtask

  task automatic test_back_to_back;
    checks_total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun_pre: got %0b want 0", overrun); else checks_passed++;
    send_msg(24'hABCDEF, 24, 1'b0, 1'b0);
    checks_total++; if (data_n3 !== 24'hABCDEF) $display("FAIL b2b_first_data: got %06h want abcdef", data_n3); else checks_passed++;
    send_msg(24'h13579B, 24, 1'b0, 1'b0);
    checks_total++; if (data_n3 !== 24'hABCDEF) $display("FAIL b2b_retained: got %06h want abcdef", data_n3); else checks_passed++;
    checks_total++; if (overrun_n3 !== 1'b1) $display("FAIL b2b_overrun: got %0b want 1", overrun_n3); else checks_passed++;
    send_msg(24'h2468AC, 24, 1'b0, 1'b1);
    checks_total++; if (valid_n3 !== 1'b1) $display("FAIL b2b_ack_valid: got %0b want 1", valid_n3); else checks_passed++;
    checks_total++; if (data_n3 !== 24'h2468AC) $display("FAIL b2b_ack_data: got %06h want 2468ac", data_n3); else checks_passed++;
  endtask

  task automatic test_reset_mid;
    send_msg(24'hF0F0F0, 11, 1'b0, 1'b0);
    rx_in = 1'b1;
    repeat (15) @(negedge clock);
    checks_total++; if (busy !== 1'b1) $display("FAIL mid_busy_pre: got %0b want 1", busy); else checks_passed++;
    reset_n = 1'b0;
    #1;
    checks_total++; if (msg_valid !== 1'b0) $display("FAIL mid_reset_valid: got %0b want 0", msg_valid); else checks_passed++;
    checks_total++; if (msg_data !== 24'h000000) $display("FAIL mid_reset_data: got %06h want 000000", msg_data); else checks_passed++;
    checks_total++; if (overrun !== 1'b0) $display("FAIL mid_reset_overrun: got %0b want 0", overrun); else checks_passed++;
    checks_total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %0b want 0", busy); else checks_passed++;
    rx_in = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    send_msg(24'h000001, 24, 1'b0, 1'b0);
    checks_total++; if (valid_n3 !== 1'b1) $display("FAIL post_reset_valid: got %0b want 1", valid_n3); else checks_passed++;
    checks_total++; if (data_n3 !== 24'h000001) $display("FAIL post_reset_data: got %06h want 000001", data_n3); else checks_passed++;
    ack_once();
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity;
    send_msg(24'h5A5A5B, 24, 1'b1, 1'b0);
    checks_total++; if (par_n3 !== 1'b1) $display("FAIL parity_err_pulse: got %0b want 1", par_n3); else checks_passed++;
    checks_total++; if (frame_n3 !== 1'b1) $display("FAIL parity_frame_pulse: got %0b want 1", frame_n3); else checks_passed++;
    checks_total++; if (valid_n3 !== 1'b0) $display("FAIL parity_valid: got %0b want 0", valid_n3); else checks_passed++;
  endtask
`endif

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset_n = 1'b0;
    rx_in   = 1'b0;
    msg_ack = 1'b0;
    rx2     = 1'b0;
    ack2    = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    test_main();
    test_threshold();
    test_timeout();
    test_runt_stuck();
    test_back_to_back();
    test_reset_mid();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
